// File: rtl/readout_sequencer_pkg.sv
// rtl/readout_sequencer_pkg.sv - shared state encoding and counter helpers for readout_sequencer
package readout_sequencer_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_GRANT = 2'd2,
    ST_END   = 2'd3
  } seq_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/readout_sequencer_if.sv
// rtl/readout_sequencer_if.sv - channel buffer side of the readout link: mask, ready, done, grant
interface readout_sequencer_if #(
  parameter int NCH = 16
);
  logic [NCH-1:0] ch_mask;
  logic [NCH-1:0] ch_ready;
  logic [NCH-1:0] ch_done;
  logic [NCH-1:0] ch_grant;

  modport master (input ch_mask, input ch_ready, input ch_done, output ch_grant);
  modport slave  (output ch_mask, output ch_ready, output ch_done, input ch_grant);
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector: first set bit strictly after ptr, wrapping
module rr_pick #(
  parameter int NCH = 16,
  parameter int IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] cand,
  input  logic [IW-1:0]  ptr,
  output logic           found,
  output logic [IW-1:0]  idx,
  output logic [NCH-1:0] onehot
);

  logic [IW-1:0] j;

  // Walk offsets from farthest to nearest so the nearest hit after ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int i = NCH; i >= 1; i--) begin
      j = IW'((int'(ptr) + i) % NCH);
      if (cand[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    onehot = found ? (NCH'(1) << idx) : '0;
  end

endmodule

// File: rtl/readout_sequencer.sv
// rtl/readout_sequencer.sv - drains pending triggered events by granting the readout link
// round-robin to every enabled channel, then advancing global_n_read.
module readout_sequencer
  import readout_sequencer_pkg::*;
#(
  parameter int NCH     = 16,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  readout_sequencer_if.master   link,
  input  logic                  live_rising,
  input  logic [CNT_W-1:0]      n_trig,
  output logic [CNT_W-1:0]      global_n_read,
  output logic                  event_active,
  output logic                  timeout_err,
  output logic [7:0]            n_timeout
);

  localparam int              IW      = $clog2(NCH);
  localparam logic [IW-1:0]   LAST_CH = IW'(NCH - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  seq_state_t       state, state_nxt;
  logic [NCH-1:0]   mask_l, mask_nxt;
  logic [NCH-1:0]   served, served_nxt;
  logic [IW-1:0]    last_grant, last_nxt;
  logic [TO_W-1:0]  to_cnt, to_nxt;
  logic [NCH-1:0]   grant_q, grant_nxt;
  logic [CNT_W-1:0] gnr_nxt;
  logic             ea_nxt, te_nxt;
  logic [7:0]       nto_nxt;

  logic             pending;
  logic [NCH-1:0]   cand;
  logic             pick_found;
  logic [IW-1:0]    pick_idx;
  logic [NCH-1:0]   pick_oh;
  logic [NCH-1:0]   cur_oh;
  logic             done_hit;
  logic             to_hit;

  assign pending  = (n_trig != global_n_read);
  assign cand     = mask_l & ~served & link.ch_ready;
  assign cur_oh   = NCH'(1) << last_grant;
  // While granted, last_grant holds the owner, so only its done pulse matters.
  assign done_hit = link.ch_done[last_grant];
  assign to_hit   = (to_cnt == TO_LAST);

  assign link.ch_grant = grant_q;

  rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
    .cand   (cand),
    .ptr    (last_grant),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  always_comb begin
    state_nxt  = state;
    mask_nxt   = mask_l;
    served_nxt = served;
    last_nxt   = last_grant;
    to_nxt     = to_cnt;
    grant_nxt  = grant_q;
    gnr_nxt    = global_n_read;
    ea_nxt     = event_active;
    te_nxt     = timeout_err;
    nto_nxt    = n_timeout;

    case (state)
      ST_IDLE: begin
        if (pending) begin
          ea_nxt = 1'b1;
          if (link.ch_mask != '0) begin
            mask_nxt   = link.ch_mask;
            served_nxt = '0;
            state_nxt  = ST_SCAN;
          end else begin
            state_nxt = ST_END;
          end
        end
      end
      ST_SCAN: begin
        if (pick_found) begin
          grant_nxt = pick_oh;
          last_nxt  = pick_idx;
          to_nxt    = '0;
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (done_hit || to_hit) begin
          served_nxt = served | cur_oh;
          grant_nxt  = '0;
          if (!done_hit) begin
            te_nxt  = 1'b1;
            nto_nxt = sat_inc8(n_timeout);
          end
          state_nxt = ((served | cur_oh) == mask_l) ? ST_END : ST_SCAN;
        end else begin
          to_nxt = to_cnt + TO_W'(1);
        end
      end
      ST_END: begin
        gnr_nxt   = global_n_read + CNT_W'(1);
        ea_nxt    = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Run start abandons whatever is in flight.
    if (live_rising) begin
      state_nxt  = ST_IDLE;
      mask_nxt   = '0;
      served_nxt = '0;
      last_nxt   = LAST_CH;
      to_nxt     = '0;
      grant_nxt  = '0;
      gnr_nxt    = '0;
      ea_nxt     = 1'b0;
      te_nxt     = 1'b0;
      nto_nxt    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      mask_l        <= '0;
      served        <= '0;
      last_grant    <= LAST_CH;
      to_cnt        <= '0;
      grant_q       <= '0;
      global_n_read <= '0;
      event_active  <= 1'b0;
      timeout_err   <= 1'b0;
      n_timeout     <= '0;
    end else begin
      state         <= state_nxt;
      mask_l        <= mask_nxt;
      served        <= served_nxt;
      last_grant    <= last_nxt;
      to_cnt        <= to_nxt;
      grant_q       <= grant_nxt;
      global_n_read <= gnr_nxt;
      event_active  <= ea_nxt;
      timeout_err   <= te_nxt;
      n_timeout     <= nto_nxt;
    end
  end

endmodule

// File: tb/tb_readout_sequencer.sv
// tb/tb_readout_sequencer.sv - self-checking bench for readout_sequencer (NCH=4, short timeout)
module tb_readout_sequencer;
  import readout_sequencer_pkg::*;

  localparam int NCH     = 4;
  localparam int TO_W    = 16;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        live_rising = 1'b0;
  logic [15:0] n_trig = '0;
  logic [15:0] global_n_read;
  logic        event_active;
  logic        timeout_err;
  logic [7:0]  n_timeout;

  readout_sequencer_if #(.NCH(NCH)) link ();

  readout_sequencer #(.NCH(NCH), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .link          (link),
    .live_rising   (live_rising),
    .n_trig        (n_trig),
    .global_n_read (global_n_read),
    .event_active  (event_active),
    .timeout_err   (timeout_err),
    .n_timeout     (n_timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  bit             resp_en = 1'b0;
  bit             noise_en = 1'b0;
  logic [NCH-1:0] withhold = '0;
  int             fixed_delay = -1;
  logic [NCH-1:0] prev_g = '0;
  int             cur_ch = 0;
  int             gcount = 0;
  int             delay = 0;
  int             grant_log[$];
  int             last_done_cyc = 0;
  int             gnr_cyc = 0;
  logic [15:0]    prev_gnr = '0;

  typedef struct {
    logic [NCH-1:0] mask;
    logic [NCH-1:0] wh;
    int             dly;
    int             n;
    int             ord[4];
    int             cycles;
    int             to_total;
    bit             lat_chk;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: observe outputs, then act as the channel buffers for the next cycle.
  task automatic tick();
    logic [NCH-1:0] g;
    @(posedge clk);
    #1;
    cyc++;
    g = link.ch_grant;
    if (global_n_read != prev_gnr) gnr_cyc = cyc;
    prev_gnr = global_n_read;
    link.ch_done = '0;
    if (g != '0 && g != prev_g) begin
      chk("grant_gap", prev_g, 0);
      chk("grant_onehot", $countones(g), 1);
      cur_ch = $clog2(g);
      gcount = 0;
      delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
      grant_log.push_back(cur_ch);
    end
    if (g == '0 && prev_g != '0 && withhold[cur_ch]) chk("timeout_len", gcount, TIMEOUT);
    if (g != '0) begin
      gcount++;
      if (resp_en && !withhold[cur_ch] && gcount == delay + 1) begin
        link.ch_done[cur_ch] = 1'b1;
        last_done_cyc = cyc;
      end
    end
    if (noise_en && $urandom_range(0, 3) == 0) link.ch_done = link.ch_done | (NCH'($urandom) & ~g);
    if (noise_en && event_active) link.ch_mask = NCH'($urandom);
    prev_g = g;
  endtask

  task automatic run_event(input logic [NCH-1:0] m, input logic [NCH-1:0] wh, input int d,
                           output int t_cycles);
    int t0;
    int budget;
    link.ch_mask = m;
    withhold = wh;
    fixed_delay = d;
    grant_log.delete();
    n_trig = n_trig + 16'd1;
    t0 = cyc;
    budget = 0;
    do begin
      tick();
      budget++;
    end while (!(global_n_read == n_trig && !event_active) && budget < 1000);
    chk("event_finish", budget < 1000, 1);
    t_cycles = gnr_cyc - t0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int ptr;
    int to_total;
    int exp_q[$];
    logic [NCH-1:0] m;
    logic [NCH-1:0] wh;
    logic [NCH-1:0] g_seen;
    int budget;

    tbl[0] = '{4'b1011, 4'b0000, 2, 3, '{0, 1, 3, 0}, 14, 0, 1'b1};
    tbl[1] = '{4'b0011, 4'b0010, 1, 2, '{0, 1, 0, 0}, 22, 1, 1'b0};
    tbl[2] = '{4'b0000, 4'b0000, 0, 0, '{0, 0, 0, 0},  2, 1, 1'b0};
    tbl[3] = '{4'b1111, 4'b0000, 0, 4, '{2, 3, 0, 1}, 10, 1, 1'b1};
    tbl[4] = '{4'b0100, 4'b0000, 3, 1, '{2, 0, 0, 0},  7, 1, 1'b1};
    tbl[5] = '{4'b1001, 4'b1001, 0, 2, '{3, 0, 0, 0}, 36, 3, 1'b0};
    tbl[6] = '{4'b0110, 4'b0000, 1, 2, '{1, 2, 0, 0},  8, 3, 1'b1};

    link.ch_mask  = '0;
    link.ch_ready = '1;
    link.ch_done  = '0;

    repeat (3) tick();
    chk("rst_grant", link.ch_grant, 0);
    chk("rst_gnr", global_n_read, 0);
    chk("rst_active", event_active, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_ntimeout", n_timeout, 0);
    rst = 1'b0;
    tick();

    resp_en = 1'b1;
    noise_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run_event(tbl[i].mask, tbl[i].wh, tbl[i].dly, t);
      chk("tbl_ngrants", grant_log.size(), tbl[i].n);
      for (int k = 0; k < tbl[i].n; k++)
        chk("tbl_order", (k < grant_log.size()) ? grant_log[k] : -1, tbl[i].ord[k]);
      chk("tbl_cycles", t, tbl[i].cycles);
      if (tbl[i].lat_chk) chk("tbl_done_to_read", gnr_cyc - last_done_cyc, 2);
      chk("tbl_gnr", global_n_read, i + 1);
      chk("tbl_ntimeout", n_timeout, tbl[i].to_total);
      chk("tbl_terr", timeout_err, tbl[i].to_total > 0);
      chk("tbl_grant_idle", link.ch_grant, 0);
    end

    // Several empty events back to back: IDLE/END pairs, link never granted.
    noise_en = 1'b0;
    link.ch_mask = '0;
    n_trig = n_trig + 16'd3;
    t = cyc;
    g_seen = '0;
    budget = 0;
    do begin
      tick();
      g_seen |= link.ch_grant;
      budget++;
    end while (!(global_n_read == n_trig && !event_active) && budget < 100);
    chk("empty_gnr", global_n_read, 10);
    chk("empty_cycles", gnr_cyc - t, 6);
    chk("empty_no_grant", g_seen, 0);

    // live_rising in the middle of a grant held by a silent channel.
    link.ch_mask = 4'b0011;
    withhold = 4'b0001;
    fixed_delay = 0;
    n_trig = n_trig + 16'd1;
    budget = 0;
    do begin
      tick();
      budget++;
    end while (link.ch_grant[0] !== 1'b1 && budget < 20);
    chk("lr_granted", link.ch_grant, 1);
    repeat (3) tick();
    resp_en = 1'b0;
    withhold = '0;
    live_rising = 1'b1;
    n_trig = '0;
    tick();
    live_rising = 1'b0;
    chk("lr_grant", link.ch_grant, 0);
    chk("lr_active", event_active, 0);
    chk("lr_gnr", global_n_read, 0);
    chk("lr_terr", timeout_err, 0);
    chk("lr_ntimeout", n_timeout, 0);
    link.ch_done = 4'b0001;
    repeat (4) tick();
    chk("lr_stray_grant", link.ch_grant, 0);
    chk("lr_stray_active", event_active, 0);
    chk("lr_stray_gnr", global_n_read, 0);

    // Randomized events against a transaction-level model of the rotation.
    resp_en = 1'b1;
    noise_en = 1'b1;
    ptr = NCH - 1;
    to_total = 0;
    for (int e = 0; e < 40; e++) begin
      m = NCH'($urandom_range(0, 15));
      wh = ($urandom_range(0, 5) == 0) ? (m & NCH'($urandom)) : '0;
      exp_q.delete();
      for (int i = 1; i <= NCH; i++)
        if (m[(ptr + i) % NCH]) exp_q.push_back((ptr + i) % NCH);
      if (exp_q.size() > 0) ptr = exp_q[$];
      to_total = to_total + $countones(wh);
      if (to_total > 255) to_total = 255;
      run_event(m, wh, -1, t);
      chk("rnd_ngrants", grant_log.size(), exp_q.size());
      for (int k = 0; k < exp_q.size(); k++)
        chk("rnd_order", (k < grant_log.size()) ? grant_log[k] : -1, exp_q[k]);
      chk("rnd_gnr", global_n_read, e + 1);
      chk("rnd_ntimeout", n_timeout, to_total);
      chk("rnd_terr", timeout_err, to_total > 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
